// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: 16x oversampling with 3-sample majority vote, framing/break/overrun
// detection, and a small show-ahead FIFO on the byte output.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rx_serial,
  input  logic                                rd_en,
  input  logic                                clr_err,
  output logic [7:0]                          rx_data,
  output logic                                rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     rx_count,
  output logic                                busy,
  output logic                                frame_err,
  output logic                                break_det,
  output logic                                overrun
);

  localparam int OVS_DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int TW      = $clog2(OVS_DIV);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_MAX = TW'(OVS_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic [TW-1:0]   tick_reg, tick_next;
  logic [3:0]      samp_reg, samp_next;
  logic            s7_reg, s7_next, s8_reg, s8_next;
  logic [7:0]      data_reg, data_next;
  logic [2:0]      bit_reg, bit_next;
  logic            ferr_reg, ferr_next, brk_reg, brk_next;
  logic            line, tick, at9, at15, maj, push;

  assign line = sync_reg[1];
  assign tick = (tick_reg == TICK_MAX);
  assign at9  = tick && (samp_reg == 4'd9);
  assign at15 = tick && (samp_reg == 4'd15);
  // Samples 7 and 8 are held; sample 9 is the live synced line at decision time.
  assign maj  = (s7_reg & s8_reg) | (s7_reg & line) | (s8_reg & line);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= 2'b11;
      state_reg <= IDLE;
      tick_reg  <= '0;
      samp_reg  <= '0;
      s7_reg    <= 1'b1;
      s8_reg    <= 1'b1;
      data_reg  <= '0;
      bit_reg   <= '0;
      ferr_reg  <= 1'b0;
      brk_reg   <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], rx_serial};
      state_reg <= state_next;
      tick_reg  <= tick_next;
      samp_reg  <= samp_next;
      s7_reg    <= s7_next;
      s8_reg    <= s8_next;
      data_reg  <= data_next;
      bit_reg   <= bit_next;
      ferr_reg  <= ferr_next;
      brk_reg   <= brk_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick ? '0 : tick_reg + TW'(1);
    samp_next  = tick ? samp_reg + 4'd1 : samp_reg;
    s7_next    = (tick && samp_reg == 4'd7) ? line : s7_reg;
    s8_next    = (tick && samp_reg == 4'd8) ? line : s8_reg;
    data_next  = data_reg;
    bit_next   = bit_reg;
    push       = 1'b0;
    ferr_next  = 1'b0;
    brk_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        samp_next = '0;
        if (!line) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (at9 && maj) begin
          state_next = IDLE;
        end else if (at15) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (at9) data_next = {maj, data_reg[7:1]};
        if (at15) begin
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end
      end
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (at9) begin
          if (maj) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            brk_next   = (data_reg == 8'h00);
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (line) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign frame_err = ferr_reg;
  assign break_det = brk_reg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full, pop, push_ok;

  assign full    = (count_reg == FULL_CNT);
  assign pop     = rd_en && rx_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // A new drop outranks a simultaneous clear.
      if (push && full && !pop) overrun <= 1'b1;
      else if (clr_err)         overrun <= 1'b0;
    end
  end

  assign rx_ready = (count_reg != '0);
  assign rx_count = count_reg;
  assign rx_data  = rx_ready ? mem[rd_ptr_reg] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo: frames are driven bit-by-bit, expected bytes
// are queued per frame, and a monitor checks every pop against the queue.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DEPTH    = 4;
  localparam int BIT      = 160;

  logic       clk = 1'b0;
  logic       rst, rx_serial, rd_en, clr_err;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [2:0] rx_count;
  logic       busy, frame_err, break_det, overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .rd_en(rd_en), .clr_err(clr_err),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_count(rx_count), .busy(busy),
    .frame_err(frame_err), .break_det(break_det), .overrun(overrun)
  );

  int         total = 0, bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  int         ferr_cnt = 0, brk_cnt = 0, exp_ferr = 0, exp_brk = 0;
  logic [7:0] mon_exp;
  logic [7:0] b2b_bytes [4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: counts error pulses and scores every pop against the expected queue.
  always @(negedge clk) begin
    #1;
    if (frame_err) ferr_cnt++;
    if (break_det) brk_cnt++;
    if (rd_en) begin
      if (exp_q.size() == 0) begin
        check("pop_on_empty_ready", rx_ready, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_ready", rx_ready, 1);
        check("pop_data", rx_data, mon_exp);
      end
    end
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_serial = 1'b1;
      rd_en     = 1'b0;
    end
  endtask

  task automatic pop_n(input int n);
    repeat (n) begin
      @(negedge clk); rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Drives one 10-bit frame at bc clocks per bit; optionally pulses rd_en at clock pop_at.
  task automatic send(input logic [7:0] b, input int bc, input logic stop_ok,
                      input int pop_at, output int ready_at);
    logic [9:0] frame;
    frame    = {stop_ok, b, 1'b0};
    ready_at = -1;
    for (int k = 0; k < 10 * bc; k++) begin
      @(negedge clk);
      rx_serial = frame[k / bc];
      rd_en     = (k == pop_at);
      #1;
      if (ready_at < 0 && rx_ready) ready_at = k;
    end
    if (stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_ovr = 1'b1;
    end else begin
      exp_ferr++;
      if (b == 8'h00) exp_brk++;
    end
    $display("frame %02h bitclks=%0d stop_ok=%0d queued=%0d", b, bc, stop_ok, exp_q.size());
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    #2;
    check({tag, "_ready"},   rx_ready, exp_q.size() != 0);
    check({tag, "_count"},   rx_count, exp_q.size());
    check({tag, "_overrun"}, overrun,  exp_ovr);
    check({tag, "_busy"},    busy,     0);
    check({tag, "_ferrs"},   ferr_cnt, exp_ferr);
    check({tag, "_breaks"},  brk_cnt,  exp_brk);
    if (exp_q.size() != 0) check({tag, "_head"}, rx_data, exp_q[0]);
  endtask

  int ra;

  initial begin
    rx_serial = 1'b1; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b1;
    b2b_bytes[0] = 8'h00; b2b_bytes[1] = 8'hFF; b2b_bytes[2] = 8'h55; b2b_bytes[3] = 8'h3C;
    repeat (3) @(negedge clk);
    #2;
    check("rst_ready", rx_ready, 0);
    check("rst_count", rx_count, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_brk", break_det, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk); rst = 1'b0;
    idle(20);

    // Single byte and its latency from the start edge.
    send(8'hA5, BIT, 1'b1, -1, ra);
    $display("latency: rx_ready seen %0d clocks after start edge", ra);
    check("latency_window", (ra >= 1530 && ra <= 1560), 1);
    idle(10);
    check_state("single");
    pop_n(1);
    check_state("single_popped");

    // Back-to-back frames, no gap.
    for (int i = 0; i < 4; i++) send(b2b_bytes[i], BIT, 1'b1, -1, ra);
    idle(10);
    check_state("b2b");
    pop_n(4);
    check_state("b2b_drained");

    // Fifth byte into a full FIFO is dropped.
    for (int i = 1; i <= 5; i++) send(8'(i), BIT, 1'b1, -1, ra);
    idle(10);
    check_state("full_drop");
    pop_n(4);
    pulse_clr();
    check_state("after_clr");

    // Pop in the same cycle as the fifth push keeps the byte.
    for (int i = 1; i <= 4; i++) send(8'(i), BIT, 1'b1, -1, ra);
    send(8'h05, BIT, 1'b1, 1542, ra);
    idle(10);
    check_state("push_pop_full");
    pop_n(4);
    check_state("push_pop_drained");

    // Bad stop bit, then recovery.
    send(8'h81, BIT, 1'b0, -1, ra);
    idle(50);
    check_state("bad_stop");
    send(8'h42, BIT, 1'b1, -1, ra);
    idle(10);
    check_state("recover");

    // Line held low: one frame error and one break.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rx_serial = 1'b0;
      if (k == 2990) begin
        #1;
        check("break_busy_held", busy, 1);
      end
    end
    exp_ferr++; exp_brk++;
    idle(50);
    check_state("break");

    // Short glitch is a false start.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rx_serial = 1'b0;
      if (k == 30) begin
        #1;
        check("glitch_busy", busy, 1);
      end
    end
    idle(200);
    check_state("glitch");

    // +/-3% rate error.
    send(8'hC3, 155, 1'b1, -1, ra);
    idle(20);
    send(8'hC3, 165, 1'b1, -1, ra);
    idle(10);
    check_state("rate_err");

    // Reset in the middle of the data bits.
    for (int k = 0; k < 4 * BIT; k++) begin
      @(negedge clk);
      rx_serial = (k < BIT) ? 1'b0 : ((k / BIT) % 2 == 0);
    end
    @(negedge clk); rst = 1'b1; rx_serial = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    #2;
    check("midrst_data", rx_data, 0);
    check_state("midrst");
    idle(20);
    send(8'h7E, BIT, 1'b1, -1, ra);
    idle(10);
    check_state("post_rst");
    pop_n(1);

    // Randomized frames, rates, stop errors and pops.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      int         bc, np;
      logic       ok;
      b  = 8'($urandom_range(0, 255));
      bc = $urandom_range(155, 165);
      ok = ($urandom_range(0, 5) != 0);
      send(b, bc, ok, -1, ra);
      idle($urandom_range(5, 40));
      np = $urandom_range(0, 2);
      pop_n(np);
      if (exp_ovr && $urandom_range(0, 1) == 1) pulse_clr();
      check_state("rand");
    end

    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
